// File: rtl/mux16_pkg.sv
// Shared definitions for the 16-bit select-bus blocks (mux and demux/collector).
package mux16_pkg;

  localparam int WIDTH = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] FULL_MASK = '1;

endpackage

// File: rtl/dec4to16.sv
// Combinational one-hot decoder: 4-bit select to 16-bit one-hot.
module dec4to16
  import mux16_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] onehot
);

  // Set exactly the bit named by sel.
  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/demux16_collect.sv
// Bit-addressed word collector: each accepted beat writes one bit at position
// sel; a word is presented once every position has been written.
//
// state   | meaning
// COLLECT | no complete word held, out_valid=0
// HOLD    | complete word on out, out_valid=1, waiting for out_ready
module demux16_collect
  import mux16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic [SEL_W-1:0] sel,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dup_err
);

  state_t           state_q;
  logic [WIDTH-1:0] collect_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] onehot;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] collect_next;
  logic             completes;
  logic             accept;
  logic             drain;

  dec4to16 u_dec (
    .sel    (sel),
    .onehot (onehot)
  );

  // Mask/word after a hypothetical write this cycle; a completing beat only
  // stalls while the previously held word is still pending.
  always_comb begin
    mask_next    = mask_q | onehot;
    collect_next = (collect_q & ~onehot) | (onehot & {WIDTH{in_bit}});
    completes    = (mask_next == FULL_MASK);
    in_ready     = rst | !out_valid | out_ready | !completes;
    // clr wins over a simultaneous beat, even if in_ready is high.
    accept       = in_valid & in_ready & !clr;
    drain        = (state_q == HOLD) & out_ready;
  end

  // FSM, collection registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      collect_q <= '0;
      mask_q    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      dup_err   <= 1'b0;
    end else begin
      if (clr) begin
        collect_q <= '0;
        mask_q    <= '0;
        dup_err   <= 1'b0;
      end else if (accept) begin
        if (completes) begin
          out       <= collect_next;
          collect_q <= '0;
          mask_q    <= '0;
        end else begin
          collect_q <= collect_next;
          mask_q    <= mask_next;
          if ((mask_q & onehot) != '0) dup_err <= 1'b1;
        end
      end

      // A new word landing in the drain cycle keeps HOLD with no bubble.
      if (accept && completes) begin
        state_q   <= HOLD;
        out_valid <= 1'b1;
      end else if (drain) begin
        state_q   <= COLLECT;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demux16_collect.sv
// Randomized and directed bench for demux16_collect with a per-position
// reference model of the collector.
module tb_demux16_collect;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_bit;
  logic [3:0]  sel;
  logic        clr;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        dup_err;

  int n_cmp = 0;
  int n_bad = 0;

  demux16_collect dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .sel       (sel),
    .clr       (clr),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dup_err   (dup_err)
  );

  always #5 clk = ~clk;

  // Reference model: which positions are written, their values, held word.
  bit          m_wr[16];
  bit          m_bits[16];
  logic [15:0] m_out;
  bit          m_hv;
  bit          m_dup;
  bit          m_known = 0;
  int          n_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready(input logic [3:0] s, input bit ordy, input bit r);
    int cnt = 0;
    if (r) return 1'b1;
    for (int i = 0; i < 16; i++) if (m_wr[i] || i == int'(s)) cnt++;
    return !m_hv || ordy || (cnt != 16);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) begin
      m_wr[i]   = 0;
      m_bits[i] = 0;
    end
  endfunction

  function automatic void model_update(input bit v, input bit b, input logic [3:0] s,
                                       input bit c, input bit ordy, input bit r, input bit rdy);
    bit comp = 0;
    bit all  = 1;
    if (r) begin
      model_clear();
      m_out = 16'h0;
      m_hv  = 0;
      m_dup = 0;
      return;
    end
    if (c) begin
      model_clear();
      m_dup = 0;
    end else if (v && rdy) begin
      n_acc++;
      if (m_wr[s]) m_dup = 1;
      m_bits[s] = b;
      m_wr[s]   = 1;
      for (int i = 0; i < 16; i++) if (!m_wr[i]) all = 0;
      if (all) begin
        for (int i = 0; i < 16; i++) m_out[i] = m_bits[i];
        model_clear();
        comp = 1;
      end
    end
    if (comp) m_hv = 1;
    else if (m_hv && ordy) m_hv = 0;
  endfunction

  // One clock: drive, compare against the model mid-cycle, clock, update model.
  task automatic step(input bit v, input bit b, input logic [3:0] s,
                      input bit c, input bit ordy, input bit r);
    bit rdy;
    rst = r; in_valid = v; in_bit = b; sel = s; clr = c; out_ready = ordy;
    #1;
    rdy = model_ready(s, ordy, r);
    if (m_known) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_hv});
      chk("out", {16'b0, out}, {16'b0, m_out});
      chk("dup_err", {31'b0, dup_err}, {31'b0, m_dup});
    end
    @(posedge clk);
    model_update(v, b, s, c, ordy, r, rdy);
    m_known = 1;
    #1;
  endtask

  task automatic idle(input bit ordy);
    step(0, 0, 4'd0, 0, ordy, 0);
  endtask

  task automatic word_in_order(input logic [15:0] w, input bit ordy);
    for (int i = 0; i < 16; i++) step(1, w[i], 4'(i), 0, ordy, 0);
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] wb;
    int          order[16];
    int          k;

    step(0, 0, 4'd0, 0, 0, 1);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out", {16'b0, out}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_dup_err", {31'b0, dup_err}, 32'd0);

    // Basic word
    w = 16'h3F0A;
    for (int i = 0; i < 15; i++) step(1, w[i], 4'(i), 0, 1, 0);
    chk("basic_not_yet", {31'b0, out_valid}, 32'd0);
    step(1, w[15], 4'd15, 0, 1, 0);
    chk("basic_out", {16'b0, out}, 32'h3F0A);
    chk("basic_valid", {31'b0, out_valid}, 32'd1);
    chk("basic_dup", {31'b0, dup_err}, 32'd0);
    idle(1);
    chk("basic_one_cycle", {31'b0, out_valid}, 32'd0);

    // Scrambled order 12, 6, 0, 15..1
    order[0] = 12; order[1] = 6; order[2] = 0;
    k = 3;
    for (int i = 15; i >= 1; i--) if (i != 12 && i != 6) begin order[k] = i; k++; end
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("scr_before_last", {31'b0, out_valid}, 32'd0);
      step(1, w[order[i]], 4'(order[i]), 0, 1, 0);
    end
    chk("scr_out", {16'b0, out}, 32'h3F0A);
    chk("scr_valid", {31'b0, out_valid}, 32'd1);
    idle(1);

    // Duplicate write to position 6
    n_acc = 0;
    step(1, 1, 4'd6, 0, 1, 0);
    chk("dup_first", {31'b0, dup_err}, 32'd0);
    step(1, 0, 4'd6, 0, 1, 0);
    chk("dup_set", {31'b0, dup_err}, 32'd1);
    for (int i = 0; i < 16; i++) if (i != 6) step(1, w[i], 4'(i), 0, 1, 0);
    chk("dup_beats", n_acc, 32'd17);
    chk("dup_out", {16'b0, out}, 32'h3F0A);
    chk("dup_bit6", {31'b0, out[6]}, 32'd0);
    chk("dup_valid", {31'b0, out_valid}, 32'd1);
    chk("dup_sticky", {31'b0, dup_err}, 32'd1);
    step(0, 0, 4'd0, 1, 1, 0);
    chk("dup_clr", {31'b0, dup_err}, 32'd0);

    // Backpressure
    w  = 16'h1234;
    wb = 16'hBEEF;
    word_in_order(w, 0);
    chk("bp_first", {16'b0, out}, 32'h1234);
    for (int i = 0; i < 15; i++) step(1, wb[i], 4'(i), 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      sel = 4'd15; out_ready = 0; rst = 0; clr = 0; in_valid = 1;
      #1 chk("bp_stall_ready", {31'b0, in_ready}, 32'd0);
      step(1, wb[15], 4'd15, 0, 0, 0);
      chk("bp_held_out", {16'b0, out}, 32'h1234);
    end
    step(1, wb[15], 4'd15, 0, 1, 0);
    chk("bp_second", {16'b0, out}, 32'hBEEF);
    chk("bp_valid", {31'b0, out_valid}, 32'd1);
    idle(1);
    chk("bp_drained", {31'b0, out_valid}, 32'd0);

    // clr mid-word with a simultaneous beat
    for (int i = 0; i < 8; i++) step(1, 1'($urandom), 4'(i), 0, 1, 0);
    step(1, 1, 4'd8, 1, 1, 0);
    word_in_order(16'hA5C3, 1);
    chk("clr_out", {16'b0, out}, 32'hA5C3);
    chk("clr_valid", {31'b0, out_valid}, 32'd1);

    // rst mid-word with a simultaneous beat
    for (int i = 0; i < 8; i++) step(1, 1'($urandom), 4'(i), 0, 0, 0);
    step(1, 1, 4'd8, 0, 0, 1);
    chk("rst_mid_out", {16'b0, out}, 32'h0);
    chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    word_in_order(16'hA5C3, 1);
    chk("rst_then_out", {16'b0, out}, 32'hA5C3);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(3) != 0, 1'($urandom), 4'($urandom_range(15)),
           $urandom_range(40) == 0, $urandom_range(2) != 0, $urandom_range(400) == 0);
    end
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
